memaccess_fsm: RTL and testbench
================================

MEMACCESS_FSM -- requirements
Module: memaccess_fsm

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: mem_state  input  3  access request from controller (0=read, 1=indirect-pointer read, 2=write, 3=idle; other codes treated as 3).
REQ-004 SHALL have port: M_Addr  input  16  effective address from execute stage.
REQ-005 SHALL have port: M_Data  input  16  store data from execute stage.
REQ-006 SHALL have port: Data_dout  input  16  data memory read data, valid only while Data_ack=1.
REQ-007 SHALL have port: Data_ack  input  1  data memory completion, one cycle, any latency >=1 cycle after Data_req rises.
REQ-008 SHALL have port: Data_req  output  1  memory request, held high until Data_ack.
REQ-009 SHALL have port: Data_rd  output  1  1=read, 0=write; valid while Data_req=1.
REQ-010 SHALL have port: Data_addr  output  16  registered access address.
REQ-011 SHALL have port: Data_din  output  16  registered write data.
REQ-012 SHALL have port: memout  output  16  last data word returned by a mem_state=0 read.
REQ-013 SHALL have port: complete_data  output  1  one-cycle pulse per finished access, consumed by controller.

Function
REQ-014 SHALL implement states IDLE, IND, RD, WR, DONE; Data_req=1 exactly in IND, RD, WR; complete_data=1 exactly in DONE.
REQ-015 IDLE SHALL sample mem_state each cycle: 1 -> IND, 0 -> RD, 2 -> WR, 3/other -> stay IDLE.
REQ-016 On launch, Data_addr SHALL load M_Addr, except RD/WR launched with ind_pending=1 load the held pointer ptr.
REQ-017 On WR launch, Data_din SHALL load M_Data; Data_din SHALL hold otherwise.
REQ-018 Data_rd SHALL be 1 in IND and RD, 0 in WR.
REQ-019 Data_addr, Data_din, Data_rd SHALL remain stable while Data_req=1 and Data_ack=0.
REQ-020 IND with Data_ack=1 SHALL load ptr<=Data_dout, set ind_pending=1, go DONE.
REQ-021 RD with Data_ack=1 SHALL load memout<=Data_dout, go DONE; memout SHALL hold at all other times.
REQ-022 WR with Data_ack=1 SHALL go DONE without changing memout.
REQ-023 Any RD or WR launch SHALL clear ind_pending (after selecting the address per REQ-016).
REQ-024 IND launch while ind_pending=1 SHALL use M_Addr and overwrite ptr on its ack.
REQ-025 DONE SHALL last exactly one cycle and return to IDLE unconditionally; mem_state sampled during DONE SHALL be ignored (prevents relaunch on stale controller state).
REQ-026 Access latency: complete_data rises exactly one cycle after the cycle Data_ack=1 is sampled.
REQ-027 Data_ack while in IDLE or DONE SHALL be ignored.
REQ-028 Change of mem_state while in IND/RD/WR SHALL be ignored until DONE.

Reset
REQ-029 rst=1 SHALL force state IDLE, Data_req=0, Data_rd=0, complete_data=0, ind_pending=0, Data_addr=0, Data_din=0, ptr=0, memout=0 at the next rising edge.
REQ-030 rst asserted mid-access SHALL abandon the access with no complete_data pulse; a late Data_ack after reset SHALL be ignored.

Verification
REQ-031 Read: mem_state=0, M_Addr=0x3000, Data_ack after 3 cycles with Data_dout=0xBEEF -> Data_addr=0x3000, Data_rd=1, memout=0xBEEF, one complete_data pulse.
REQ-032 Write: mem_state=2, M_Addr=0x4010, M_Data=0x1234, ack after 1 cycle -> Data_rd=0, Data_din=0x1234, memout unchanged, one pulse.
REQ-033 LDI: mem_state=1, M_Addr=0x3005, ack Data_dout=0x5000; then mem_state=0, ack Data_dout=0x00AA -> second access at Data_addr=0x5000, memout=0x00AA, two pulses, ind_pending=0 after.
REQ-034 STI: mem_state 1 then 2, pointer 0x6000, M_Data=0x7777 -> write at 0x6000 with Data_din=0x7777.
REQ-035 Stale state: mem_state held at 0 through DONE -> relaunch only from IDLE on the cycle after DONE, never during DONE.
REQ-036 Reset mid-RD: rst pulse before ack, ack arrives after -> Data_req=0, memout=0, no complete_data.

Source files
------------

// File: rtl/memaccess_fsm.sv
// Data-memory access sequencer: launches read, indirect-pointer read and write
// requests, holds them until the memory acknowledges, then pulses completion.
module memaccess_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mem_state,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  input  logic [15:0] Data_dout,
  input  logic        Data_ack,
  output logic        Data_req,
  output logic        Data_rd,
  output logic [15:0] Data_addr,
  output logic [15:0] Data_din,
  output logic [15:0] memout,
  output logic        complete_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IND,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_data_req;
  logic        r_data_rd;
  logic [15:0] r_data_addr;
  logic [15:0] r_data_din;
  logic [15:0] r_memout;
  logic        r_complete;
  logic        r_ind_pending;
  logic [15:0] r_ptr;

  logic        w_use_ptr;
  logic [15:0] w_launch_addr;

  // A read or write following an indirect-pointer fetch goes to the fetched pointer.
  assign w_use_ptr     = r_ind_pending && ((mem_state == 3'd0) || (mem_state == 3'd2));
  assign w_launch_addr = w_use_ptr ? r_ptr : M_Addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_data_req    <= 1'b0;
      r_data_rd     <= 1'b0;
      r_data_addr   <= 16'h0000;
      r_data_din    <= 16'h0000;
      r_memout      <= 16'h0000;
      r_complete    <= 1'b0;
      r_ind_pending <= 1'b0;
      r_ptr         <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          case (mem_state)
            3'd1: begin
              r_state     <= S_IND;
              r_data_req  <= 1'b1;
              r_data_rd   <= 1'b1;
              r_data_addr <= M_Addr;
            end
            3'd0: begin
              r_state       <= S_RD;
              r_data_req    <= 1'b1;
              r_data_rd     <= 1'b1;
              r_data_addr   <= w_launch_addr;
              r_ind_pending <= 1'b0;
            end
            3'd2: begin
              r_state       <= S_WR;
              r_data_req    <= 1'b1;
              r_data_rd     <= 1'b0;
              r_data_addr   <= w_launch_addr;
              r_data_din    <= M_Data;
              r_ind_pending <= 1'b0;
            end
            default: r_state <= S_IDLE;
          endcase
        end

        S_IND: begin
          if (Data_ack) begin
            r_ptr         <= Data_dout;
            r_ind_pending <= 1'b1;
            r_data_req    <= 1'b0;
            r_complete    <= 1'b1;
            r_state       <= S_DONE;
          end
        end

        S_RD: begin
          if (Data_ack) begin
            r_memout   <= Data_dout;
            r_data_req <= 1'b0;
            r_complete <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        S_WR: begin
          if (Data_ack) begin
            r_data_req <= 1'b0;
            r_complete <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        // Controller state seen here is stale, so never relaunch from DONE.
        S_DONE: begin
          r_complete <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_data_req <= 1'b0;
          r_complete <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign Data_req      = r_data_req;
  assign Data_rd       = r_data_rd;
  assign Data_addr     = r_data_addr;
  assign Data_din      = r_data_din;
  assign memout        = r_memout;
  assign complete_data = r_complete;

endmodule

// File: tb/tb_memaccess_fsm.sv
// Directed bench for memaccess_fsm: a table of single-access vectors applied in
// order, plus hand-written sequences for stale state, idle acks and mid-access reset.
module tb_memaccess_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_state;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic [15:0] Data_dout;
  logic        Data_ack;
  logic        Data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] memout;
  logic        complete_data;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;

  typedef struct {
    logic [2:0]  ms;
    logic [15:0] addr;
    logic [15:0] data;
    int          lat;
    logic [15:0] dout;
    logic [15:0] expAddr;
    logic        expRd;
    logic [15:0] expDin;
    logic [15:0] expMemout;
  } vec_t;

  vec_t vecs[11];

  memaccess_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .mem_state     (mem_state),
    .M_Addr        (M_Addr),
    .M_Data        (M_Data),
    .Data_dout     (Data_dout),
    .Data_ack      (Data_ack),
    .Data_req      (Data_req),
    .Data_rd       (Data_rd),
    .Data_addr     (Data_addr),
    .Data_din      (Data_din),
    .memout        (memout),
    .complete_data (complete_data)
  );

  always #5 clk = ~clk;

  // Completion pulses are counted away from the active edge.
  always @(negedge clk) begin
    if (complete_data) pulseCount++;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {15'b0, act}, {15'b0, exp});
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One full access: launch from IDLE, wait lat cycles with a changing
  // mem_state, acknowledge, then watch DONE return to IDLE.
  task automatic applyStimulus(input vec_t v, input string tag);
    int p0;
    @(negedge clk);
    mem_state = v.ms;
    M_Addr    = v.addr;
    M_Data    = v.data;
    p0        = pulseCount;
    @(posedge clk); #1;
    mem_state = (v.ms == 3'd0) ? 3'd1 : 3'd0;
    checkBit({tag, "_req"}, Data_req, 1'b1);
    checkOutput({tag, "_addr"}, Data_addr, v.expAddr);
    checkBit({tag, "_rd"}, Data_rd, v.expRd);
    checkOutput({tag, "_din"}, Data_din, v.expDin);
    for (int c = 1; c < v.lat; c++) begin
      @(posedge clk); #1;
      checkBit({tag, "_req_hold"}, Data_req, 1'b1);
      checkOutput({tag, "_addr_hold"}, Data_addr, v.expAddr);
      checkBit({tag, "_rd_hold"}, Data_rd, v.expRd);
      checkBit({tag, "_cmp_wait"}, complete_data, 1'b0);
    end
    Data_ack  = 1'b1;
    Data_dout = v.dout;
    @(posedge clk); #1;
    Data_ack  = 1'b0;
    mem_state = 3'd3;
    checkBit({tag, "_cmp"}, complete_data, 1'b1);
    checkBit({tag, "_req_drop"}, Data_req, 1'b0);
    checkOutput({tag, "_memout"}, memout, v.expMemout);
    @(posedge clk); #1;
    checkBit({tag, "_cmp_end"}, complete_data, 1'b0);
    checkBit({tag, "_req_idle"}, Data_req, 1'b0);
    checkCount({tag, "_pulses"}, pulseCount - p0, 1);
  endtask

  initial begin
    int p0;
    vec_t tmp;

    vecs[0]  = '{3'd0, 16'h3000, 16'h0000, 3, 16'hBEEF, 16'h3000, 1'b1, 16'h0000, 16'hBEEF};
    vecs[1]  = '{3'd2, 16'h4010, 16'h1234, 1, 16'hDEAD, 16'h4010, 1'b0, 16'h1234, 16'hBEEF};
    vecs[2]  = '{3'd1, 16'h3005, 16'h9999, 2, 16'h5000, 16'h3005, 1'b1, 16'h1234, 16'hBEEF};
    vecs[3]  = '{3'd0, 16'h1111, 16'h0000, 1, 16'h00AA, 16'h5000, 1'b1, 16'h1234, 16'h00AA};
    vecs[4]  = '{3'd0, 16'h2222, 16'h0000, 2, 16'h0BBB, 16'h2222, 1'b1, 16'h1234, 16'h0BBB};
    vecs[5]  = '{3'd1, 16'h3100, 16'h0000, 1, 16'h6000, 16'h3100, 1'b1, 16'h1234, 16'h0BBB};
    vecs[6]  = '{3'd2, 16'h0001, 16'h7777, 4, 16'h0000, 16'h6000, 1'b0, 16'h7777, 16'h0BBB};
    vecs[7]  = '{3'd2, 16'h4444, 16'h5555, 1, 16'h0000, 16'h4444, 1'b0, 16'h5555, 16'h0BBB};
    vecs[8]  = '{3'd1, 16'h3200, 16'h0000, 1, 16'h8000, 16'h3200, 1'b1, 16'h5555, 16'h0BBB};
    vecs[9]  = '{3'd1, 16'h3300, 16'h0000, 1, 16'h9000, 16'h3300, 1'b1, 16'h5555, 16'h0BBB};
    vecs[10] = '{3'd0, 16'h0000, 16'h0000, 2, 16'h1357, 16'h9000, 1'b1, 16'h5555, 16'h1357};

    rst       = 1'b1;
    mem_state = 3'd3;
    M_Addr    = 16'h0000;
    M_Data    = 16'h0000;
    Data_dout = 16'h0000;
    Data_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkBit("rst_req", Data_req, 1'b0);
    checkBit("rst_rd", Data_rd, 1'b0);
    checkBit("rst_cmp", complete_data, 1'b0);
    checkOutput("rst_addr", Data_addr, 16'h0000);
    checkOutput("rst_din", Data_din, 16'h0000);
    checkOutput("rst_memout", memout, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Undefined request code and a stray ack in IDLE must both be ignored.
    $display("[TB] idle ignore sequence");
    @(negedge clk);
    mem_state = 3'd7;
    p0        = pulseCount;
    Data_ack  = 1'b1;
    Data_dout = 16'hFFFF;
    @(posedge clk); #1;
    Data_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkBit("idle_req", Data_req, 1'b0);
    checkBit("idle_cmp", complete_data, 1'b0);
    checkOutput("idle_memout", memout, 16'h1357);
    checkCount("idle_pulses", pulseCount - p0, 0);
    mem_state = 3'd3;

    // mem_state held at read through DONE: relaunch only after an IDLE cycle.
    $display("[TB] stale state sequence");
    @(negedge clk);
    mem_state = 3'd0;
    M_Addr    = 16'h0700;
    p0        = pulseCount;
    @(posedge clk); #1;
    checkBit("stale_req1", Data_req, 1'b1);
    Data_ack  = 1'b1;
    Data_dout = 16'h0A0A;
    @(posedge clk); #1;
    Data_ack = 1'b0;
    checkBit("stale_cmp1", complete_data, 1'b1);
    checkBit("stale_req_done", Data_req, 1'b0);
    @(posedge clk); #1;
    checkBit("stale_no_relaunch", Data_req, 1'b0);
    checkBit("stale_cmp_idle", complete_data, 1'b0);
    @(posedge clk); #1;
    checkBit("stale_req2", Data_req, 1'b1);
    checkOutput("stale_addr2", Data_addr, 16'h0700);
    mem_state = 3'd3;
    Data_ack  = 1'b1;
    Data_dout = 16'h0B0B;
    @(posedge clk); #1;
    Data_ack = 1'b0;
    checkOutput("stale_memout", memout, 16'h0B0B);
    @(posedge clk); #1;
    checkCount("stale_pulses", pulseCount - p0, 2);

    // Reset in the middle of a pointer-based read, followed by a late ack.
    $display("[TB] reset mid-access sequence");
    tmp = '{3'd1, 16'h3400, 16'h0000, 1, 16'hC000, 16'h3400, 1'b1, 16'h5555, 16'h0B0B};
    applyStimulus(tmp, "rs_ind");
    @(negedge clk);
    mem_state = 3'd0;
    M_Addr    = 16'hA000;
    p0        = pulseCount;
    @(posedge clk); #1;
    mem_state = 3'd3;
    checkOutput("rs_rd_addr", Data_addr, 16'hC000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkBit("rs_req", Data_req, 1'b0);
    checkBit("rs_cmp", complete_data, 1'b0);
    checkOutput("rs_memout", memout, 16'h0000);
    checkOutput("rs_addr", Data_addr, 16'h0000);
    checkOutput("rs_din", Data_din, 16'h0000);
    Data_ack  = 1'b1;
    Data_dout = 16'hFFFF;
    @(posedge clk); #1;
    Data_ack = 1'b0;
    @(posedge clk); #1;
    checkBit("rs_late_cmp", complete_data, 1'b0);
    checkOutput("rs_late_memout", memout, 16'h0000);
    checkCount("rs_pulses", pulseCount - p0, 0);
    tmp = '{3'd0, 16'h0123, 16'h0000, 1, 16'h2468, 16'h0123, 1'b1, 16'h0000, 16'h2468};
    applyStimulus(tmp, "rs_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
